// File: rtl/sar_compare_search.sv
// Successive-approximation search controller: walks a trial operand bit by bit
// against an external magnitude comparator until the held target is resolved.
//
//  state | meaning
//  IDLE  | waiting for start; outputs hold the last search
//  PROBE | one comparator probe per cycle, current bit marked by bit_mask
//  DONE  | one-cycle done pulse; start here restarts immediately
module sar_compare_search #(
    parameter int WIDTH = 4,
    localparam int PCW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [PCW-1:0]   probe_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] bit_mask, bit_mask_nx;
    logic [WIDTH-1:0] trial_nx, result_nx, trial_upd;
    logic [PCW-1:0]   probe_cnt_nx;
    logic             err_nx, flags_onehot;

    // One-hot bit mask stands in for the bit index, so no subtractor is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_mask  <= '0;
            trial     <= '0;
            result    <= '0;
            err       <= 1'b0;
            probe_cnt <= '0;
        end else begin
            state     <= state_nx;
            bit_mask  <= bit_mask_nx;
            trial     <= trial_nx;
            result    <= result_nx;
            err       <= err_nx;
            probe_cnt <= probe_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_mask_nx  = bit_mask;
        trial_nx     = trial;
        result_nx    = result;
        err_nx       = err;
        probe_cnt_nx = probe_cnt;
        trial_upd    = cmp_lt ? (trial & ~bit_mask) : trial;
        flags_onehot = 1'b0;
        case ({cmp_lt, cmp_eq, cmp_gt})
            3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
            default:                flags_onehot = 1'b0;
        endcase

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx     = PROBE;
                    bit_mask_nx  = MSB_MASK;
                    trial_nx     = MSB_MASK;
                    err_nx       = 1'b0;
                    probe_cnt_nx = '0;
                end else if (state == DONE) begin
                    state_nx = IDLE;
                end
            end
            PROBE: begin
                probe_cnt_nx = probe_cnt + PCW'(1);
                if (!flags_onehot) begin
                    err_nx    = 1'b1;
                    result_nx = trial & ~bit_mask;
                    state_nx  = DONE;
                end else if (cmp_eq) begin
                    result_nx = trial;
                    state_nx  = DONE;
                end else if (bit_mask[0]) begin
                    trial_nx  = trial_upd;
                    result_nx = trial_upd;
                    state_nx  = DONE;
                end else begin
                    bit_mask_nx = bit_mask >> 1;
                    trial_nx    = trial_upd | (bit_mask >> 1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == PROBE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sar_compare_search.sv
// Scoreboarded bench for sar_compare_search: a behavioural comparator holds the
// target, expected results are queued at start and checked when done pulses.
module tb_sar_compare_search;

    localparam int WIDTH = 4;
    localparam int PCW   = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst, start;
    logic             cmp_lt, cmp_eq, cmp_gt;
    logic [WIDTH-1:0] trial, result;
    logic             busy, done, err;
    logic [PCW-1:0]   probe_cnt;

    logic [WIDTH-1:0] target;
    logic             bad_flags;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             err;
        logic [PCW-1:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_done = 1'b0;

    sar_compare_search #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq),
        .cmp_gt    (cmp_gt),
        .trial     (trial),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .probe_cnt (probe_cnt)
    );

    always #5 clk = ~clk;

    // Comparator: target vs trial, or a forced lt+gt collision.
    assign cmp_lt = bad_flags ? 1'b1 : (target < trial);
    assign cmp_eq = bad_flags ? 1'b0 : (target == trial);
    assign cmp_gt = bad_flags ? 1'b1 : (target > trial);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (done) begin
            chk("done_single_cycle", int'(prev_done), 0);
            chk("busy_low_at_done", int'(busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("err", int'(err), int'(e.err));
                chk("probe_cnt", int'(probe_cnt), int'(e.cnt));
            end
        end
        prev_done = done;
    end

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] exp_res,
                       input logic exp_err, input int exp_cnt,
                       input bit inject_bad, input bit mid_start);
        int lat;
        target = tgt;
        start  = 1'b1;
        exp_q.push_back('{res: exp_res, err: exp_err, cnt: PCW'(exp_cnt)});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bad_flags = inject_bad && (lat == 1);
            start     = mid_start && (lat == 1);
        end
        bad_flags = 1'b0;
        start     = 1'b0;
        chk("latency", lat, exp_cnt);
    endtask

    task automatic idle_gap();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bad_flags = 1'b0;
        target    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_trial", int'(trial), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_cnt", int'(probe_cnt), 0);
        chk("rst_flags", int'({busy, done, err}), 0);
        rst = 1'b0;
        @(negedge clk);

        run(4'd0,  4'd0,  1'b0, 4, 1'b0, 1'b0);  idle_gap();
        run(4'd8,  4'd8,  1'b0, 1, 1'b0, 1'b0);  idle_gap();
        run(4'd15, 4'd15, 1'b0, 4, 1'b0, 1'b0);  idle_gap();
        run(4'd5,  4'd5,  1'b0, 4, 1'b0, 1'b0);  idle_gap();
        run(4'd12, 4'd12, 1'b0, 2, 1'b0, 1'b0);  idle_gap();
        run(4'd6,  4'd6,  1'b0, 3, 1'b0, 1'b0);  idle_gap();
        // trials 8 gt, then 12 with lt+gt -> result 12 with bit 2 cleared
        run(4'd10, 4'd8,  1'b1, 2, 1'b1, 1'b0);  idle_gap();
        run(4'd3,  4'd3,  1'b0, 4, 1'b0, 1'b1);  idle_gap();
        // back-to-back: second start lands in the DONE cycle
        run(4'd7,  4'd7,  1'b0, 4, 1'b0, 1'b0);
        run(4'd9,  4'd9,  1'b0, 4, 1'b0, 1'b0);  idle_gap();

        // reset during the second probe cycle
        target = 4'd15;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_trial", int'(trial), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_cnt", int'(probe_cnt), 0);
        chk("midrst_flags", int'({busy, done, err}), 0);
        @(negedge clk);
        chk("midrst_stays_idle", int'(busy), 0);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
